// File: rtl/bldc_pkg.sv
// Shared types, lookup tables and helpers for the BLDC six-step commutation controller.
package bldc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD  = 3'd1,
    RUN   = 3'd2,
    BRAKE = 3'd3,
    FLT   = 3'd4
  } state_e;

  localparam logic [2:0]  SECTOR_NONE = 3'd0;
  localparam int unsigned NUM_SECTORS = 6;

  // Gate vectors are ordered {A, AA, B, BB, C, CC}
  localparam logic [5:0] HIGH_MASK = 6'b101010;
  localparam logic [5:0] BRAKE_PAT = 6'b010101;

  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    logic [2:0] s;
    case (code)
      3'b001:  s = 3'd1;
      3'b101:  s = 3'd2;
      3'b100:  s = 3'd3;
      3'b110:  s = 3'd4;
      3'b010:  s = 3'd5;
      3'b011:  s = 3'd6;
      default: s = SECTOR_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [5:0] fwd_pattern(input logic [2:0] sector);
    logic [5:0] p;
    case (sector)
      3'd1:    p = 6'b100100;
      3'd2:    p = 6'b100001;
      3'd3:    p = 6'b001001;
      3'd4:    p = 6'b011000;
      3'd5:    p = 6'b010010;
      3'd6:    p = 6'b000110;
      default: p = 6'b000000;
    endcase
    return p;
  endfunction

  // Reverse rotation: high and low switch of each phase trade places
  function automatic logic [5:0] swap_sides(input logic [5:0] p);
    return {p[4], p[5], p[2], p[3], p[0], p[1]};
  endfunction

  function automatic logic is_adjacent(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] a_up;
    logic [2:0] b_up;
    a_up = (a == 3'(NUM_SECTORS)) ? 3'd1 : a + 3'd1;
    b_up = (b == 3'(NUM_SECTORS)) ? 3'd1 : b + 3'd1;
    return (b == a_up) || (a == b_up);
  endfunction

endpackage

// File: rtl/bldc_commutation_ctrl_hall_debounce.sv
// Hall input conditioning: 2-flop synchroniser, debounce counter and registered sector decode.
module hall_debounce
  import bldc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall,
  output logic [2:0] sector,
  output logic       hall_bad
);

  localparam int unsigned CW = 8;

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [1:0]    sync_ok;
  logic [2:0]    cand;
  logic [2:0]    deb_code;
  logic          deb_valid;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt_c;

  // Count consecutive equal samples, restarting at 1 when the code changes
  always_comb begin
    cnt_nxt_c = cnt;
    if (sync2 != cand) begin
      cnt_nxt_c = CW'(1);
    end else if (cnt != CW'(DEB_CYCLES)) begin
      cnt_nxt_c = cnt + CW'(1);
    end
  end

  // Samples shifted in from reset are not real Hall codes; sync_ok gates them out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_ok   <= '0;
      cand      <= '0;
      cnt       <= '0;
      deb_code  <= '0;
      deb_valid <= 1'b0;
      sector    <= SECTOR_NONE;
      hall_bad  <= 1'b0;
    end else begin
      sync1   <= hall;
      sync2   <= sync1;
      sync_ok <= {sync_ok[0], 1'b1};
      if (sync_ok[1]) begin
        cand <= sync2;
        cnt  <= cnt_nxt_c;
        if (cnt_nxt_c == CW'(DEB_CYCLES)) begin
          deb_code  <= sync2;
          deb_valid <= 1'b1;
        end
      end
      sector   <= deb_valid ? hall_to_sector(deb_code) : SECTOR_NONE;
      hall_bad <= deb_valid && ((deb_code == 3'b000) || (deb_code == 3'b111));
    end
  end

endmodule

// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation sequencer: sequence checking, dead time, high-side PWM,
// braking and latched Hall fault.
module bldc_commutation_ctrl
  import bldc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned DEAD_CYCLES = 8,
  parameter int unsigned PWM_DIV     = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       H1,
  input  logic       H2,
  input  logic       H3,
  input  logic       D3,
  input  logic       D2,
  input  logic       D1,
  input  logic       D0,
  input  logic       EN,
  input  logic       DIR,
  input  logic       LOW,
  output logic       A_OUT,
  output logic       B_OUT,
  output logic       C_OUT,
  output logic       AA_OUT,
  output logic       BB_OUT,
  output logic       CC_OUT,
  output logic [2:0] SECTOR,
  output logic       FAULT
);

  localparam int unsigned DIVW  = 8;
  localparam int unsigned DEADW = 8;

  logic [3:0]       duty_c;
  logic             hall_bad;
  logic [DIVW-1:0]  div_cnt;
  logic [3:0]       pwm_cnt;
  logic             pwm_on_c;
  logic             en_q;
  logic             fault_q;
  logic [2:0]       last_sec;
  logic             seq_active_c;
  logic             jump_c;
  logic             fault_set_c;
  logic             en_fall_c;
  state_e           state;
  logic [2:0]       tgt_sector;
  logic             tgt_dir;
  logic             tgt_low;
  logic [DEADW-1:0] dead_cnt;
  logic [5:0]       gates;
  logic             target_chg_c;
  logic [5:0]       drive_c;

  assign duty_c = {D3, D2, D1, D0};

  hall_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_hall (
    .clk      (CLK),
    .rst_n    (RST_N),
    .hall     ({H3, H2, H1}),
    .sector   (SECTOR),
    .hall_bad (hall_bad)
  );

  // PWM timebase: 4-bit counter stepping every PWM_DIV clocks
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else if (div_cnt == DIVW'(PWM_DIV - 1)) begin
      div_cnt <= '0;
      pwm_cnt <= pwm_cnt + 4'd1;
    end else begin
      div_cnt <= div_cnt + DIVW'(1);
    end
  end

  assign pwm_on_c = (pwm_cnt < duty_c);

  // Sector jumps are only judged once the bridge has left IDLE
  always_comb begin
    seq_active_c = (state == DEAD) || (state == RUN) || (state == BRAKE);
    jump_c       = seq_active_c && (SECTOR != SECTOR_NONE) && (last_sec != SECTOR_NONE) &&
                   (SECTOR != last_sec) && !is_adjacent(last_sec, SECTOR);
    fault_set_c  = EN && (hall_bad || jump_c);
    en_fall_c    = en_q && !EN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      en_q     <= 1'b0;
      fault_q  <= 1'b0;
      last_sec <= SECTOR_NONE;
    end else begin
      en_q <= EN;
      if (SECTOR != SECTOR_NONE) last_sec <= SECTOR;
      if (en_fall_c)        fault_q <= 1'b0;
      else if (fault_set_c) fault_q <= 1'b1;
    end
  end

  assign FAULT = fault_q;

  // Live target; drive pattern with the high side chopped by PWM
  always_comb begin
    target_chg_c = (SECTOR != tgt_sector) || (DIR != tgt_dir) || (LOW != tgt_low);
    drive_c      = DIR ? swap_sides(fwd_pattern(SECTOR)) : fwd_pattern(SECTOR);
    if (!pwm_on_c) drive_c = drive_c & ~HIGH_MASK;
  end

  // Commutation FSM; every change of gate pattern passes through DEAD with all gates off
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      tgt_sector <= SECTOR_NONE;
      tgt_dir    <= 1'b0;
      tgt_low    <= 1'b0;
      dead_cnt   <= '0;
      gates      <= '0;
    end else if (fault_q || fault_set_c) begin
      state <= FLT;
      gates <= '0;
    end else if (!EN) begin
      state <= IDLE;
      gates <= '0;
    end else begin
      case (state)
        IDLE: begin
          gates <= '0;
          if (SECTOR != SECTOR_NONE) begin
            state      <= DEAD;
            tgt_sector <= SECTOR;
            tgt_dir    <= DIR;
            tgt_low    <= LOW;
            dead_cnt   <= '0;
          end
        end
        DEAD: begin
          gates <= '0;
          if (target_chg_c) begin
            tgt_sector <= SECTOR;
            tgt_dir    <= DIR;
            tgt_low    <= LOW;
            dead_cnt   <= '0;
          end else if (dead_cnt == DEADW'(DEAD_CYCLES - 1)) begin
            if (LOW) begin
              state <= BRAKE;
              gates <= BRAKE_PAT;
            end else if (SECTOR == SECTOR_NONE) begin
              state <= IDLE;
            end else begin
              state <= RUN;
              gates <= drive_c;
            end
          end else begin
            dead_cnt <= dead_cnt + DEADW'(1);
          end
        end
        RUN: begin
          if (target_chg_c) begin
            state      <= DEAD;
            tgt_sector <= SECTOR;
            tgt_dir    <= DIR;
            tgt_low    <= LOW;
            dead_cnt   <= '0;
            gates      <= '0;
          end else begin
            gates <= drive_c;
          end
        end
        BRAKE: begin
          if (!LOW) begin
            state      <= DEAD;
            tgt_sector <= SECTOR;
            tgt_dir    <= DIR;
            tgt_low    <= LOW;
            dead_cnt   <= '0;
            gates      <= '0;
          end else begin
            gates <= BRAKE_PAT;
          end
        end
        FLT: begin
          state <= IDLE;
          gates <= '0;
        end
        default: begin
          state <= IDLE;
          gates <= '0;
        end
      endcase
    end
  end

  assign {A_OUT, AA_OUT, B_OUT, BB_OUT, C_OUT, CC_OUT} = gates;

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Self-checking bench for bldc_commutation_ctrl with a sector/phase reference model.
module tb_bldc_commutation_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] h = 3'b001;
  logic [3:0] duty = 4'd6;
  logic       en = 1'b1;
  logic       dir = 1'b0;
  logic       low = 1'b0;
  logic       a_out, b_out, c_out, aa_out, bb_out, cc_out;
  logic [2:0] sector;
  logic       fault;
  wire  [5:0] g = {a_out, aa_out, b_out, bb_out, c_out, cc_out};

  int n_cmp = 0;
  int n_mis = 0;
  int cur = 0;
  int hall_of [7] = '{0, 1, 5, 4, 6, 2, 3};

  always #5 clk = ~clk;

  bldc_commutation_ctrl dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .H1     (h[0]),
    .H2     (h[1]),
    .H3     (h[2]),
    .D3     (duty[3]),
    .D2     (duty[2]),
    .D1     (duty[1]),
    .D0     (duty[0]),
    .EN     (en),
    .DIR    (dir),
    .LOW    (low),
    .A_OUT  (a_out),
    .B_OUT  (b_out),
    .C_OUT  (c_out),
    .AA_OUT (aa_out),
    .BB_OUT (bb_out),
    .CC_OUT (cc_out),
    .SECTOR (sector),
    .FAULT  (fault)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      assert (((a_out & aa_out) | (b_out & bb_out) | (c_out & cc_out)) === 1'b0)
      else begin
        n_mis++;
        $error("FAIL overlap: observed gates %b expected no same-phase pair", g);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Phase index 0=A,1=B,2=C; forward high phase A,A,B,B,C,C and low phase B,C,C,A,A,B
  function automatic int hi_phase(input int s, input bit d);
    return d ? ((s / 2 + 1) % 3) : ((s - 1) / 2);
  endfunction

  function automatic int lo_phase(input int s, input bit d);
    return d ? ((s - 1) / 2) : ((s / 2 + 1) % 3);
  endfunction

  task automatic wait_gap(output int gap);
    int t;
    t   = 0;
    gap = 0;
    while (g != 6'd0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    while (g == 6'd0 && gap < 60) begin
      @(negedge clk);
      gap++;
    end
  endtask

  task automatic check_run(input string tag, input int s, input bit d, input int dt);
    int         hp, lp, hi_n, lo_n;
    logic [5:0] allowed, stray;
    hp = hi_phase(s, d);
    lp = lo_phase(s, d);
    allowed = '0;
    allowed[5-2*hp] = 1'b1;
    allowed[4-2*lp] = 1'b1;
    hi_n  = 0;
    lo_n  = 0;
    stray = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      hi_n += int'(g[5-2*hp]);
      lo_n += int'(g[4-2*lp]);
      stray |= g & ~allowed;
    end
    check({tag, "_hi"}, hi_n, dt);
    check({tag, "_lo"}, lo_n, 16);
    check({tag, "_stray"}, 32'(stray), 0);
  endtask

  task automatic step_to(input int ns);
    int gap;
    duty = 4'($urandom_range(0, 15));
    h    = 3'(hall_of[ns]);
    repeat (6) @(negedge clk);
    check("sec_hold", sector, cur);
    @(negedge clk);
    check("sec_new", sector, ns);
    wait_gap(gap);
    check("dead_gap", gap, 8);
    check("fault_run", fault, 0);
    check_run("run", ns, dir, int'(duty));
    cur = ns;
    repeat ($urandom_range(0, 40)) @(negedge clk);
  endtask

  initial begin
    int gap, zeros, moved, bn, ns;

    repeat (3) @(negedge clk);
    check("rst_gates", g, 0);
    check("rst_sector", sector, 0);
    check("rst_fault", fault, 0);
    rst_n = 1'b1;

    // Start-up latency from reset release with H=001 held
    repeat (6) @(negedge clk);
    check("lat_sec_pre", sector, 0);
    @(negedge clk);
    check("lat_sec", sector, 1);
    repeat (8) @(negedge clk);
    check("lat_dead", g, 0);
    @(negedge clk);
    check("lat_bb", bb_out, 1);
    cur = 1;
    check_run("s1_pwm", 1, 1'b0, 6);

    for (int s = 2; s <= 6; s++) step_to(s);
    step_to(1);

    repeat (10) begin
      ns = ($urandom_range(0, 1) != 0) ? (cur % 6 + 1) : ((cur + 4) % 6 + 1);
      step_to(ns);
    end
    while (cur != 2) step_to(cur % 6 + 1);

    // Short glitch to the next code must not be accepted
    h = 3'(hall_of[cur % 6 + 1]);
    repeat (3) @(negedge clk);
    h = 3'(hall_of[cur]);
    zeros = 0;
    moved = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (g == 6'd0) zeros++;
      if (sector != 3'(cur)) moved++;
    end
    check("glitch_gap", zeros, 0);
    check("glitch_sec", moved, 0);

    // Brake in S2 and back
    low = 1'b1;
    wait_gap(gap);
    check("brake_gap", gap, 8);
    bn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (g == 6'b010101) bn++;
    end
    check("brake_pat", bn, 8);
    low = 1'b0;
    wait_gap(gap);
    check("unbrake_gap", gap, 8);
    check_run("unbrake", 2, 1'b0, int'(duty));

    // Direction reversal in S2
    dir = 1'b1;
    wait_gap(gap);
    check("rev_gap", gap, 8);
    check_run("rev", 2, 1'b1, int'(duty));
    dir = 1'b0;
    wait_gap(gap);
    check("fwd_gap", gap, 8);
    check_run("fwd", 2, 1'b0, int'(duty));

    // Illegal jump S2 -> S4
    h = 3'(hall_of[4]);
    repeat (7) @(negedge clk);
    check("jump_sec", sector, 4);
    check("jump_pre", fault, 0);
    @(negedge clk);
    check("jump_fault", fault, 1);
    check("jump_gates", g, 0);
    repeat (10) @(negedge clk);
    check("jump_latched", fault, 1);
    check("jump_off", g, 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("jump_clear", fault, 0);
    en = 1'b1;
    wait_gap(gap);
    check("restart_gap", gap, 9);
    check_run("restart", 4, 1'b0, int'(duty));
    cur = 4;

    // Invalid Hall code while running
    h = 3'b000;
    repeat (8) @(negedge clk);
    check("h000_fault", fault, 1);
    check("h000_gates", g, 0);
    h = 3'(hall_of[4]);
    repeat (12) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("h000_clear", fault, 0);
    en = 1'b1;
    wait_gap(gap);
    check("h000_restart_gap", gap, 9);
    check_run("h000_restart", 4, 1'b0, int'(duty));

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gates", g, 0);
    check("async_rst_sector", sector, 0);
    check("async_rst_fault", fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
